// File: rtl/video_expand_24to30_pkg.sv
// Shared video constants and the 8->10 bit channel expansion used by the
// capture-to-processing width expander.
package video_expand_24to30_pkg;

   localparam int IN_CH_W  = 8;
   localparam int OUT_CH_W = 10;
   localparam int CNT_W    = 12;

   // MSB replication keeps full-scale white at full scale (8'hFF -> 10'h3FF).
   function automatic logic [OUT_CH_W-1:0] expand_ch(input logic [IN_CH_W-1:0] x);
      return {x, x[IN_CH_W-1 -: (OUT_CH_W - IN_CH_W)]};
   endfunction

endpackage

// File: rtl/video_expand_24to30_skid_buf.sv
// Generic 2-entry AXI4-Stream skid buffer; the input ready is a flop so there
// is no combinational path from downstream ready back to upstream.
module axis_skid_buf #(
   parameter int DATA_W = 34
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready
);

   logic [DATA_W-1:0] main_q, main_nxt, skid_q, skid_nxt;
   logic              main_vld_q, main_vld_nxt, skid_vld_q, skid_vld_nxt;
   logic              accept, xfer;

   assign accept = s_valid && s_ready;
   assign xfer   = main_vld_q && m_ready;

   always_comb begin
      main_nxt     = main_q;
      main_vld_nxt = main_vld_q;
      skid_nxt     = skid_q;
      skid_vld_nxt = skid_vld_q;
      if (skid_vld_q) begin
         // s_ready is low here, so no accept can collide with the refill.
         if (xfer) begin
            main_nxt     = skid_q;
            skid_vld_nxt = 1'b0;
         end
      end else if (accept) begin
         if (!main_vld_q || xfer) begin
            main_nxt     = s_data;
            main_vld_nxt = 1'b1;
         end else begin
            skid_nxt     = s_data;
            skid_vld_nxt = 1'b1;
         end
      end else if (xfer) begin
         main_vld_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         main_q     <= '0;
         main_vld_q <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
         s_ready    <= 1'b0;
      end else begin
         main_q     <= main_nxt;
         main_vld_q <= main_vld_nxt;
         skid_q     <= skid_nxt;
         skid_vld_q <= skid_vld_nxt;
         // Track the next skid state so ready drops on the edge the skid fills.
         s_ready    <= !skid_vld_nxt;
      end
   end

   assign m_data  = main_q;
   assign m_valid = main_vld_q;

endmodule

// File: rtl/video_expand_24to30.sv
// 24-bit RGB to 30-bit (in 32) RGB AXI4-Stream expander with skid-buffered
// handshake, line/frame geometry checking and a frame counter.
module video_expand_24to30
   import video_expand_24to30_pkg::*;
#(
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 720
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [23:0] s_axis_video_tdata,
   input  logic        s_axis_video_tvalid,
   input  logic        s_axis_video_tuser,
   input  logic        s_axis_video_tlast,
   output logic        s_axis_video_tready,
   output logic [31:0] m_axis_video_tdata,
   output logic        m_axis_video_tvalid,
   output logic        m_axis_video_tuser,
   output logic        m_axis_video_tlast,
   input  logic        m_axis_video_tready,
   input  logic        err_clr,
   output logic        line_err,
   output logic        frame_err,
   output logic [15:0] frame_cnt
);

   localparam int                 PAYLOAD_W = 34;
   localparam logic [CNT_W-1:0]   H_BEATS   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0]   V_LINES   = CNT_W'(V_ACTIVE);

   logic [PAYLOAD_W-1:0] in_payload, out_payload;
   logic                 accept;
   logic [CNT_W-1:0]     px_cnt, px_nxt, px_base, px_inc;
   logic [CNT_W-1:0]     line_cnt, line_nxt, line_base;
   logic                 seen_sof, line_err_set, frame_err_set;

   assign in_payload = {s_axis_video_tuser, s_axis_video_tlast, 2'b00,
                        expand_ch(s_axis_video_tdata[23:16]),
                        expand_ch(s_axis_video_tdata[15:8]),
                        expand_ch(s_axis_video_tdata[7:0])};

   axis_skid_buf #(.DATA_W(PAYLOAD_W)) u_skid (
      .clk     (clk),
      .rstn    (rstn),
      .s_data  (in_payload),
      .s_valid (s_axis_video_tvalid),
      .s_ready (s_axis_video_tready),
      .m_data  (out_payload),
      .m_valid (m_axis_video_tvalid),
      .m_ready (m_axis_video_tready)
   );

   assign m_axis_video_tuser = out_payload[33];
   assign m_axis_video_tlast = out_payload[32];
   assign m_axis_video_tdata = out_payload[31:0];

   assign accept = s_axis_video_tvalid && s_axis_video_tready;

   // Geometry checker: an SOF beat restarts both counters and counts as beat 1.
   always_comb begin
      px_nxt        = px_cnt;
      line_nxt      = line_cnt;
      px_base       = px_cnt;
      line_base     = line_cnt;
      line_err_set  = 1'b0;
      frame_err_set = 1'b0;
      if (accept && s_axis_video_tuser) begin
         px_base   = '0;
         line_base = '0;
         if (px_cnt != '0) line_err_set = 1'b1;
         if (seen_sof && line_cnt != V_LINES) frame_err_set = 1'b1;
      end
      px_inc = px_base + CNT_W'(1);
      if (accept) begin
         px_nxt   = px_inc;
         line_nxt = line_base;
         if (s_axis_video_tlast) begin
            if (px_inc != H_BEATS) line_err_set = 1'b1;
            px_nxt   = '0;
            line_nxt = line_base + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         px_cnt    <= '0;
         line_cnt  <= '0;
         seen_sof  <= 1'b0;
         frame_cnt <= '0;
         line_err  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         px_cnt   <= px_nxt;
         line_cnt <= line_nxt;
         if (accept && s_axis_video_tuser) begin
            seen_sof  <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
         end
         // A fresh error wins over a simultaneous clear.
         if (line_err_set)  line_err <= 1'b1;
         else if (err_clr)  line_err <= 1'b0;
         if (frame_err_set) frame_err <= 1'b1;
         else if (err_clr)  frame_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_video_expand_24to30.sv
// Directed scoreboard bench for video_expand_24to30 with small frame geometry.
module tb_video_expand_24to30;

   localparam int H = 4;
   localparam int V = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [23:0] s_tdata = '0;
   logic        s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic        m_tvalid, m_tuser, m_tlast;
   logic        m_tready = 1'b0;
   logic        err_clr = 1'b0;
   logic        line_err, frame_err;
   logic [15:0] frame_cnt;

   logic [33:0] sb[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic        acc = 1'b0;

   video_expand_24to30 #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk                 (clk),
      .rstn                (rstn),
      .s_axis_video_tdata  (s_tdata),
      .s_axis_video_tvalid (s_tvalid),
      .s_axis_video_tuser  (s_tuser),
      .s_axis_video_tlast  (s_tlast),
      .s_axis_video_tready (s_tready),
      .m_axis_video_tdata  (m_tdata),
      .m_axis_video_tvalid (m_tvalid),
      .m_axis_video_tuser  (m_tuser),
      .m_axis_video_tlast  (m_tlast),
      .m_axis_video_tready (m_tready),
      .err_clr             (err_clr),
      .line_err            (line_err),
      .frame_err           (frame_err),
      .frame_cnt           (frame_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [9:0] x10(input logic [7:0] x);
      return {x, x[7:6]};
   endfunction

   function automatic logic [33:0] exp_beat(input logic [23:0] d, input logic u, input logic l);
      return {u, l, 2'b00, x10(d[23:16]), x10(d[15:8]), x10(d[7:0])};
   endfunction

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Output side of the scoreboard.
   always @(negedge clk) begin
      if (rstn && m_tvalid && m_tready) begin
         if (sb.size() == 0) chk("unexpected_beat", {m_tuser, m_tlast, m_tdata}, 34'h0);
         else chk("beat", {m_tuser, m_tlast, m_tdata}, sb.pop_front());
      end
   end

   task automatic tick();
      @(negedge clk);
      acc = s_tvalid && s_tready;
      if (acc) sb.push_back(exp_beat(s_tdata, s_tuser, s_tlast));
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] d, input logic u, input logic l);
      int n = 0;
      s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
      do begin tick(); n++; end while (!acc && n < 50);
      if (!acc) chk("send_timeout", 34'd0, 34'd1);
      s_tvalid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin tick(); n++; end
      chk("drain_empty", 34'(sb.size()), 34'd0);
   endtask

   task automatic reset_pulse();
      s_tvalid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      sb.delete();
      chk("rst_m_tvalid", 34'(m_tvalid), 34'd0);
      chk("rst_m_tdata", 34'(m_tdata), 34'd0);
      chk("rst_s_tready", 34'(s_tready), 34'd0);
      chk("rst_frame_cnt", 34'(frame_cnt), 34'd0);
      chk("rst_errs", 34'({line_err, frame_err}), 34'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      chk("tready_low_at_release", 34'(s_tready), 34'd0);
      @(posedge clk); #1;
      chk("tready_rise", 34'(s_tready), 34'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed hang expected finish");
      $fatal(1);
   end

   initial begin
      int t0, k;
      reset_pulse();

      // Single full-scale/mid-scale beat
      m_tready = 1'b1;
      send(24'hFF8000, 1'b1, 1'b1);
      chk("single_tdata", 34'(m_tdata), 34'h3FF80800);
      chk("single_user_last", 34'({m_tuser, m_tlast, m_tvalid}), 34'b111);
      chk("short_line_err", 34'(line_err), 34'd1);
      chk("first_sof_no_frame_err", 34'(frame_err), 34'd0);
      drain();
      reset_pulse();

      // Three well-formed frames back to back
      m_tready = 1'b1;
      t0 = cyc;
      for (int f = 0; f < 3; f++)
         for (int b = 0; b < H * V; b++)
            send(24'($urandom), b == 0, (b % H) == H - 1);
      chk("throughput_cycles", 34'(cyc - t0), 34'(3 * H * V));
      drain();
      chk("stream_frame_cnt", 34'(frame_cnt), 34'd3);
      chk("stream_errs", 34'({line_err, frame_err}), 34'd0);

      // Backpressure: one 4-beat line offered while downstream stalls
      m_tready = 1'b0;
      k = 0;
      s_tdata = 24'($urandom); s_tuser = 1'b1; s_tlast = 1'b0; s_tvalid = 1'b1;
      for (int i = 0; i < 60 && k < 4; i++) begin
         if (i == 5) begin
            chk("bp_accepted", 34'(k), 34'd2);
            chk("bp_tready_low", 34'(s_tready), 34'd0);
            chk("bp_m_tvalid", 34'(m_tvalid), 34'd1);
            m_tready = 1'b1;
         end
         tick();
         if (acc) begin
            k++;
            s_tdata = 24'($urandom); s_tuser = 1'b0; s_tlast = (k == 3);
         end
      end
      s_tvalid = 1'b0;
      chk("bp_total_accepted", 34'(k), 34'd4);
      drain();
      chk("bp_frame_cnt", 34'(frame_cnt), 34'd4);

      // Short line, then clear
      chk("pre_line_err", 34'(line_err), 34'd0);
      for (int b = 0; b < 3; b++) send(24'($urandom), 1'b0, b == 2);
      chk("line_err_set", 34'(line_err), 34'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("line_err_cleared", 34'(line_err), 34'd0);
      chk("frame_err_quiet", 34'(frame_err), 34'd0);

      // Frame with 2 lines closes fine; next SOF after 1 line flags frame_err
      for (int b = 0; b < H; b++) send(24'($urandom), b == 0, b == H - 1);
      chk("good_frame_no_err", 34'({line_err, frame_err}), 34'd0);
      for (int b = 0; b < H; b++) send(24'($urandom), b == 0, b == H - 1);
      chk("frame_err_set", 34'(frame_err), 34'd1);
      chk("frame_err_line_ok", 34'(line_err), 34'd0);
      chk("frame_cnt_6", 34'(frame_cnt), 34'd6);
      drain();

      // Reset while both entries are occupied
      m_tready = 1'b0;
      send(24'h123456, 1'b1, 1'b0);
      send(24'hABCDEF, 1'b0, 1'b0);
      chk("full_tready_low", 34'(s_tready), 34'd0);
      chk("full_m_tvalid", 34'(m_tvalid), 34'd1);
      reset_pulse();
      m_tready = 1'b1;
      tick(); tick();
      chk("post_rst_no_beats", 34'(m_tvalid), 34'd0);
      chk("post_rst_frame_cnt", 34'(frame_cnt), 34'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/video_expand_24to30.md
# video_expand_24to30

AXI4-Stream video width expander: accepts 24-bit RGB (8 bits per channel) and emits 32-bit words carrying 10 bits per channel (bits 29:0, bits 31:30 zero), the packing consumed by the 10-bit video processing path. It sits between the 8-bit capture/VDMA side and the 10-bit pipeline. It is a full-handshake register slice with a 2-entry skid buffer, so it honours backpressure without combinational ready paths. It also checks line length and frame height, and counts frames.

## Interface
- H_ACTIVE, 1280: expected beats per line (1..4095).
- V_ACTIVE, 720: expected lines per frame (1..4095).
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- s_axis_video_tdata  in  24  {R[23:16], G[15:8], B[7:0]}.
- s_axis_video_tvalid  in  1  input beat valid.
- s_axis_video_tuser  in  1  start of frame, on the first beat of a frame.
- s_axis_video_tlast  in  1  end of line.
- s_axis_video_tready  out  1  input ready; registered.
- m_axis_video_tdata  out  32  {2'b00, R10, G10, B10}.
- m_axis_video_tvalid  out  1  output beat valid.
- m_axis_video_tuser  out  1  passed through with its beat.
- m_axis_video_tlast  out  1  passed through with its beat.
- m_axis_video_tready  in  1  downstream ready.
- err_clr  in  1  synchronous clear of the sticky error flags.
- line_err  out  1  sticky: a line had the wrong length.
- frame_err  out  1  sticky: a frame had the wrong number of lines.
- frame_cnt  out  16  count of accepted SOF beats; wraps at 16'hFFFF to 0.

## Operation
- Expansion: each channel is expanded by bit replication, x10 = {x8, x8[7:6]]. So 8'h00 gives 10'h000, 8'hFF gives 10'h3FF, and 8'h80 gives 10'h202.
- Output packing: R10 at out[29:20], G10 at out[19:10], B10 at out[9:0], with out[31:30] = 0.
- Storage: a main register M (drives the m_ outputs) and a skid register S. Each holds expanded data, tuser, tlast and a valid bit.
- Input accept = s_tvalid && s_tready. Output transfer = m_tvalid && m_tready.
- s_tready is a flop, driven to !S.valid at every edge.
- On an accept:
  - If !M.valid, or M is transferring in the same cycle (and S is empty), the beat goes to M.
  - Otherwise it goes to S.
- On a transfer with S.valid: S moves into M and S is cleared. Any new accept that cycle cannot happen, because s_tready = 0 while S is valid.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- Beat counter px_cnt (12 bits) advances on every accepted beat.
  - On an accepted tlast: if px_cnt+1 != H_ACTIVE, set line_err. Then px_cnt = 0 and line_cnt increments.
  - On an accepted tuser with px_cnt != 0: set line_err (truncated line). Then px_cnt restarts, so the tuser beat counts as beat 1.
- Line counter line_cnt (12 bits) restarts on an accepted tuser.
  - If a previous SOF has already been seen (seen_sof flag) and line_cnt != V_ACTIVE at that point, set frame_err.
  - The first frame after reset is never flagged.
- frame_cnt increments on every accepted tuser.
- err_clr clears line_err and frame_err. If an error is detected in the same cycle as err_clr, the set wins.
- All checks operate on input accepts only; downstream stalls have no effect on them.

## Timing
- Reset values: all m_ outputs 0, s_tready 0, line_err 0, frame_err 0, frame_cnt 0, and all internal counters and flags 0.
- s_tready rises at the first clk edge after rstn deasserts.
- Latency: an accepted beat appears on the m_ outputs 1 cycle later when M is free.
- Throughput: 1 beat per clock while m_tready = 1.
- Backpressure:
  - With m_tready = 0 and M full, the next accepted beat fills S.
  - s_tready drops the following cycle.
  - At most 2 beats are ever held.
- No combinational path from m_tready to s_tready.
- m_tdata, m_tuser and m_tlast are stable while m_tvalid = 1 and m_tready = 0.
- Asserting rstn mid-frame empties M and S immediately (asynchronously). The beats held in them are lost, and all counters and flags reset.

## Structure
- A shared video package holds the channel-width constants (8, 10), the replicate-expand function, and the 12-bit counter width.
- One sub-module, axis_skid_buf: a generic 2-entry skid buffer parameterised on payload width (here 32 + tuser + tlast). The expansion logic and the checker live in the top module.

## Test plan
- Single beat 24'hFF8000 with tuser = 1, tlast = 1, m_tready = 1 -> after 1 cycle, m_tdata = 32'h3FF80800 with tuser = 1 and tlast = 1.
- Streaming with H_ACTIVE = 4, V_ACTIVE = 2 and well-formed frames, back to back over 3 frames -> 1 beat per clock, frame_cnt = 3, line_err = 0, frame_err = 0.
- m_tready held low for 5 cycles while s_tvalid = 1 -> exactly 2 beats are accepted and s_tready drops. After release, the beats appear in order, with none lost or duplicated.
- A line of 3 beats with H_ACTIVE = 4 -> line_err = 1 the cycle after that tlast is accepted. Pulse err_clr -> line_err = 0.
- The second SOF arrives after only 1 line with V_ACTIVE = 2 -> frame_err = 1. The first SOF after reset does not set it.
- Assert rstn low while M and S are full -> m_tvalid = 0 and s_tready = 0 immediately. After release, s_tready rises 1 cycle later and frame_cnt = 0.
